// File: rtl/rgf_uart_bus_master_if.sv
// Bus-side bundle of the register-file UART bus master: UART byte RX/TX
// handshakes plus the single-master register bus toward the address decoder.
interface rgf_uart_bus_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic                  bus_wr_en;
  logic                  bus_rd_en;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  busy;

  modport master (
    input  rx_data, rx_valid, tx_ready, bus_rdata,
    output tx_data, tx_valid, bus_addr, bus_wr_en, bus_rd_en, bus_wdata, busy
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, bus_rdata,
    input  tx_data, tx_valid, bus_addr, bus_wr_en, bus_rd_en, bus_wdata, busy
  );
endinterface

// File: rtl/rgf_uart_bus_master.sv
// UART command frames ('W' addr d0..d3 / 'R' addr) to single-cycle register bus strobes.
// Optional RGF_UART_BUS_MASTER_ERR_EN: 'E' reply on bad command or timeout, plus err_cnt.
module rgf_uart_bus_master #(
  parameter int          ADDR_WIDTH     = 8,
  parameter int          DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  rgf_uart_bus_master_if.master       bus
`ifdef RGF_UART_BUS_MASTER_ERR_EN
  ,
  output logic [7:0]                  err_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    BUS_WR   = 3'd3,
    BUS_RD   = 3'd4,
    SEND     = 3'd5
  } state_e;

  localparam logic [7:0]  CMD_WR  = 8'h57;
  localparam logic [7:0]  CMD_RD  = 8'h52;
  localparam logic [7:0]  RSP_ACK = 8'h4B;
  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 32'd0);
  localparam logic [31:0] TO_LAST = TO_EN ? 32'(TIMEOUT_CYCLES - 32'd1) : 32'd0;

  state_e                state_q;
  logic                  wr_q;
  logic [1:0]            byte_cnt_q;
  logic [2:0]            tx_left_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [31:0]           to_cnt_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic [DATA_WIDTH-1:0] bus_wdata_q;
  logic                  bus_wr_en_q;
  logic                  bus_rd_en_q;
  logic [7:0]            tx_data_q;
  logic                  tx_valid_q;
  logic                  busy_q;

`ifdef RGF_UART_BUS_MASTER_ERR_EN
  localparam logic [7:0] RSP_ERR = 8'h45;
  logic [7:0] err_cnt_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  assign err_cnt = err_cnt_q;
`endif

  // Frame decoder, bus strobe generator and response serializer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      byte_cnt_q  <= 2'd0;
      tx_left_q   <= 3'd0;
      shift_q     <= '0;
      to_cnt_q    <= 32'd0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_wr_en_q <= 1'b0;
      bus_rd_en_q <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef RGF_UART_BUS_MASTER_ERR_EN
      err_cnt_q   <= 8'h00;
`endif
    end else begin
      bus_wr_en_q <= 1'b0;
      bus_rd_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.rx_valid) begin
            to_cnt_q <= 32'd0;
            case (bus.rx_data)
              CMD_WR: begin
                wr_q    <= 1'b1;
                busy_q  <= 1'b1;
                state_q <= GET_ADDR;
              end
              CMD_RD: begin
                wr_q    <= 1'b0;
                busy_q  <= 1'b1;
                state_q <= GET_ADDR;
              end
              default: begin
`ifdef RGF_UART_BUS_MASTER_ERR_EN
                tx_data_q  <= RSP_ERR;
                tx_valid_q <= 1'b1;
                tx_left_q  <= 3'd1;
                busy_q     <= 1'b1;
                err_cnt_q  <= sat_inc8(err_cnt_q);
                state_q    <= SEND;
`else
                state_q    <= IDLE;
`endif
              end
            endcase
          end else begin
            state_q <= IDLE;
          end
        end
        GET_ADDR, GET_DATA: begin
          if (bus.rx_valid) begin
            to_cnt_q <= 32'd0;
            if (state_q == GET_ADDR) begin
              bus_addr_q <= ADDR_WIDTH'(bus.rx_data);
              byte_cnt_q <= 2'd0;
              if (wr_q) begin
                state_q <= GET_DATA;
              end else begin
                bus_rd_en_q <= 1'b1;
                state_q     <= BUS_RD;
              end
            end else begin
              bus_wdata_q[{byte_cnt_q, 3'b000} +: 8] <= bus.rx_data;
              byte_cnt_q <= byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                bus_wr_en_q <= 1'b1;
                state_q     <= BUS_WR;
              end else begin
                state_q <= GET_DATA;
              end
            end
          end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
            // Host went silent mid-frame: abandon it without touching the bus.
            to_cnt_q <= 32'd0;
`ifdef RGF_UART_BUS_MASTER_ERR_EN
            tx_data_q  <= RSP_ERR;
            tx_valid_q <= 1'b1;
            tx_left_q  <= 3'd1;
            err_cnt_q  <= sat_inc8(err_cnt_q);
            state_q    <= SEND;
`else
            busy_q     <= 1'b0;
            state_q    <= IDLE;
`endif
          end else if (TO_EN) begin
            to_cnt_q <= to_cnt_q + 32'd1;
          end else begin
            to_cnt_q <= 32'd0;
          end
        end
        BUS_WR: begin
          tx_data_q  <= RSP_ACK;
          tx_valid_q <= 1'b1;
          tx_left_q  <= 3'd1;
          state_q    <= SEND;
        end
        BUS_RD: begin
          // Responder drives bus_rdata combinationally during the strobe cycle.
          shift_q    <= bus.bus_rdata;
          tx_data_q  <= bus.bus_rdata[7:0];
          tx_valid_q <= 1'b1;
          tx_left_q  <= 3'd4;
          state_q    <= SEND;
        end
        SEND: begin
          if (bus.tx_ready) begin
            if (tx_left_q == 3'd1) begin
              tx_valid_q <= 1'b0;
              tx_left_q  <= 3'd0;
              busy_q     <= 1'b0;
              state_q    <= IDLE;
            end else begin
              tx_data_q <= shift_q[15:8];
              shift_q   <= shift_q >> 8;
              tx_left_q <= tx_left_q - 3'd1;
            end
          end else begin
            state_q <= SEND;
          end
        end
        default: begin
          tx_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wr_en = bus_wr_en_q;
  assign bus.bus_rd_en = bus_rd_en_q;
  assign bus.bus_wdata = bus_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_rgf_uart_bus_master.sv
// Directed self-checking bench for rgf_uart_bus_master (TIMEOUT_CYCLES=16).
module tb_rgf_uart_bus_master;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rgf_uart_bus_master_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus_if ();

`ifdef RGF_UART_BUS_MASTER_ERR_EN
  logic [7:0] err_cnt;
`endif

  rgf_uart_bus_master #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(32),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus_if)
`ifdef RGF_UART_BUS_MASTER_ERR_EN
    ,
    .err_cnt(err_cnt)
`endif
  );

  // Register responder: 0x0C holds a fixed word, other addresses echo the address.
  always_comb begin
    bus_if.bus_rdata = (bus_if.bus_addr == 8'h0C) ? 32'h00AB_CDEF : {16'hA5A5, 8'h00, bus_if.bus_addr};
  end

  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  logic [7:0] txq[$];
  logic [7:0] rd_exp [4] = '{8'hEF, 8'hCD, 8'hAB, 8'h00};
  logic [7:0] rd8_exp [4] = '{8'h08, 8'h00, 8'hA5, 8'hA5};

  // Strobe counters and accepted TX byte log.
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus_if.bus_wr_en) wr_cnt <= wr_cnt + 1;
      if (bus_if.bus_rd_en) rd_cnt <= rd_cnt + 1;
      if (bus_if.bus_wr_en && bus_if.bus_rd_en) both_cnt <= both_cnt + 1;
      if (bus_if.tx_valid && bus_if.tx_ready) txq.push_back(bus_if.tx_data);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    tick(1);
    bus_if.rx_valid = 1'b0;
  endtask

  function automatic logic [31:0] q_at(input int i);
    return (i < txq.size()) ? {24'h0, txq[i]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bus_if.rx_valid = 1'b0;
    bus_if.rx_data  = 8'h00;
    bus_if.tx_ready = 1'b0;
    #2;
    check_eq("rst_tx_valid", {31'd0, bus_if.tx_valid}, 32'd0);
    check_eq("rst_tx_data", {24'd0, bus_if.tx_data}, 32'd0);
    check_eq("rst_addr", {24'd0, bus_if.bus_addr}, 32'd0);
    check_eq("rst_strobes", {30'd0, bus_if.bus_wr_en, bus_if.bus_rd_en}, 32'd0);
    check_eq("rst_wdata", bus_if.bus_wdata, 32'd0);
    check_eq("rst_busy", {31'd0, bus_if.busy}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);

    // Write frame with latency checks.
    bus_if.tx_ready = 1'b1;
    send_byte(8'h57);
    check_eq("wr_busy", {31'd0, bus_if.busy}, 32'd1);
    send_byte(8'h04); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    check_eq("wr_strobe", {30'd0, bus_if.bus_wr_en, bus_if.bus_rd_en}, 32'd2);
    check_eq("wr_addr", {24'd0, bus_if.bus_addr}, 32'h04);
    check_eq("wr_wdata", bus_if.bus_wdata, 32'h1234_5678);
    check_eq("wr_txv_early", {31'd0, bus_if.tx_valid}, 32'd0);
    tick(1);
    check_eq("wr_strobe_off", {31'd0, bus_if.bus_wr_en}, 32'd0);
    check_eq("wr_ack", {23'd0, bus_if.tx_valid, bus_if.tx_data}, {23'd0, 1'b1, 8'h4B});
    tick(1);
    check_eq("wr_done", {30'd0, bus_if.tx_valid, bus_if.busy}, 32'd0);
    check_eq("wr_txq_n", txq.size(), 32'd1);
    check_eq("wr_txq0", q_at(0), 32'h4B);
    txq.delete();

    // Read frame, zero-wait TX: one byte per cycle.
    send_byte(8'h52); send_byte(8'h0C);
    check_eq("rd_strobe", {30'd0, bus_if.bus_wr_en, bus_if.bus_rd_en}, 32'd1);
    check_eq("rd_addr", {24'd0, bus_if.bus_addr}, 32'h0C);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check_eq("rd_byte", {23'd0, bus_if.tx_valid, bus_if.tx_data}, {23'd0, 1'b1, rd_exp[i]});
    end
    tick(1);
    check_eq("rd_done", {30'd0, bus_if.tx_valid, bus_if.busy}, 32'd0);
    txq.delete();

    // Read with tx_ready held low 5 cycles per byte.
    bus_if.tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h0C);
    tick(1);
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 5; k++) begin
        check_eq("bp_hold", {23'd0, bus_if.tx_valid, bus_if.tx_data}, {23'd0, 1'b1, rd_exp[i]});
        tick(1);
      end
      bus_if.tx_ready = 1'b1;
      tick(1);
      bus_if.tx_ready = 1'b0;
    end
    check_eq("bp_done", {30'd0, bus_if.tx_valid, bus_if.busy}, 32'd0);
    check_eq("bp_txq_n", txq.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("bp_txq", q_at(i), {24'd0, rd_exp[i]});
    txq.delete();

    // Unknown command byte.
    bus_if.tx_ready = 1'b1;
    send_byte(8'h00);
    tick(3);
    check_eq("garb_busy", {31'd0, bus_if.busy}, 32'd0);
`ifdef RGF_UART_BUS_MASTER_ERR_EN
    check_eq("garb_txq_n", txq.size(), 32'd1);
    check_eq("garb_txq0", q_at(0), 32'h45);
    check_eq("garb_err_cnt", {24'd0, err_cnt}, 32'd1);
`else
    check_eq("garb_txq_n", txq.size(), 32'd0);
`endif
    txq.delete();

    // Inter-byte timeout mid write frame.
    send_byte(8'h57); send_byte(8'h08); send_byte(8'h11);
    tick(10);
    check_eq("to_busy_wait", {31'd0, bus_if.busy}, 32'd1);
    tick(10);
    check_eq("to_busy_idle", {31'd0, bus_if.busy}, 32'd0);
    check_eq("to_no_write", wr_cnt, 32'd1);
`ifdef RGF_UART_BUS_MASTER_ERR_EN
    check_eq("to_txq0", q_at(0), 32'h45);
    check_eq("to_err_cnt", {24'd0, err_cnt}, 32'd2);
`else
    check_eq("to_txq_n", txq.size(), 32'd0);
`endif
    txq.delete();
    send_byte(8'h52); send_byte(8'h08);
    check_eq("to_rd_strobe", {30'd0, bus_if.bus_wr_en, bus_if.bus_rd_en}, 32'd1);
    check_eq("to_rd_addr", {24'd0, bus_if.bus_addr}, 32'h08);
    tick(6);
    check_eq("to_rd_txq_n", txq.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("to_rd_txq", q_at(i), {24'd0, rd8_exp[i]});
    txq.delete();

    // Reset mid write frame.
    send_byte(8'h57); send_byte(8'h04); send_byte(8'h01);
    rst_n = 1'b0;
    #2;
    check_eq("mrst_busy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("mrst_wdata", bus_if.bus_wdata, 32'd0);
    check_eq("mrst_addr", {24'd0, bus_if.bus_addr}, 32'd0);
    check_eq("mrst_tx", {30'd0, bus_if.tx_valid, bus_if.bus_wr_en}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    send_byte(8'h57); send_byte(8'h10);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    check_eq("mrst_wr_strobe", {31'd0, bus_if.bus_wr_en}, 32'd1);
    check_eq("mrst_wr_addr", {24'd0, bus_if.bus_addr}, 32'h10);
    check_eq("mrst_wr_wdata", bus_if.bus_wdata, 32'hDDCC_BBAA);
    tick(3);
    check_eq("mrst_done", {31'd0, bus_if.busy}, 32'd0);
    txq.delete();

    // Byte arriving during SEND is dropped.
    bus_if.tx_ready = 1'b0;
    send_byte(8'h52); send_byte(8'h0C);
    tick(1);
    send_byte(8'h57);
    bus_if.tx_ready = 1'b1;
    tick(6);
    check_eq("drop_busy", {31'd0, bus_if.busy}, 32'd0);
    check_eq("drop_txq_n", txq.size(), 32'd4);
    for (int i = 0; i < 4; i++) check_eq("drop_txq", q_at(i), {24'd0, rd_exp[i]});
    send_byte(8'h57); send_byte(8'h20);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    check_eq("drop_wr_strobe", {31'd0, bus_if.bus_wr_en}, 32'd1);
    check_eq("drop_wr_addr", {24'd0, bus_if.bus_addr}, 32'h20);
    check_eq("drop_wr_wdata", bus_if.bus_wdata, 32'h0403_0201);
    tick(3);

    check_eq("total_writes", wr_cnt, 32'd3);
    check_eq("total_reads", rd_cnt, 32'd4);
    check_eq("strobe_overlap", both_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgf_uart_bus_master.md
Name: rgf_uart_bus_master

Overview:
- Initiator side of the register-file bus. Turns UART RX command frames into single-cycle register write/read strobes, and returns an ack or the read data as UART TX bytes.
- Sits between the UART byte RX/TX blocks and the address decoder that feeds every RGF block: PWM, image pipeline, etc.
- Only master on the bus; one transaction in flight.

Parameters:
- ADDR_WIDTH, 8, bus address width. Upper bits are block select, decoded externally into addr_decoder_leg.
- DATA_WIDTH, 32, bus data width. Fixed at 4 bytes per word.
- TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles. 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- tx_data  out  8  byte to transmit
- tx_valid  out  1  tx_data valid, held until accepted
- tx_ready  in  1  UART TX accepts the byte when tx_valid && tx_ready
- bus_addr  out  ADDR_WIDTH  register address
- bus_wr_en  out  1  one-cycle write strobe
- bus_rd_en  out  1  one-cycle read strobe
- bus_wdata  out  DATA_WIDTH  write data
- bus_rdata  in  DATA_WIDTH  read data, combinational from responder in the same cycle as bus_rd_en
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0 (tx_data, tx_valid, bus_addr, bus_wr_en, bus_rd_en, bus_wdata, busy); internal data, byte counter and timeout counter cleared. Reset mid-frame aborts the frame with no bus strobe issued.
- Frame format:
  - Write: 0x57 ('W'), addr, d0, d1, d2, d3 (LSB first).
  - Read: 0x52 ('R'), addr.
  - The addr byte is zero-extended or truncated to ADDR_WIDTH.
- States: IDLE, GET_ADDR, GET_DATA, BUS_WR, BUS_RD, SEND.
- IDLE:
  - rx 0x57 -> GET_ADDR with wr flag set.
  - rx 0x52 -> GET_ADDR with wr flag clear.
  - Any other byte is discarded; stay in IDLE.
- GET_ADDR, on rx byte:
  - Latch bus_addr.
  - Write -> GET_DATA with byte_cnt=0.
  - Read -> BUS_RD.
- GET_DATA, on rx byte:
  - Store into bus_wdata[8*byte_cnt +: 8]; byte_cnt increments.
  - On the 4th byte -> BUS_WR.
- BUS_WR: bus_wr_en=1 for exactly one cycle. Load tx_data=0x4B ('K'), byte count 1 -> SEND.
- BUS_RD: bus_rd_en=1 for exactly one cycle. Capture bus_rdata at that edge, load tx_data=rdata[7:0], byte count 4 -> SEND.
- SEND:
  - tx_valid=1, tx_data stable until handshake.
  - On tx_valid && tx_ready: if more bytes remain, the next byte (LSB first) is presented the next cycle with tx_valid kept high; after the last byte, tx_valid=0 -> IDLE.
- bus_addr and bus_wdata hold their last values outside strobe cycles; strobes are never asserted simultaneously.
- Latency:
  - Write: last data byte accepted at edge N -> bus_wr_en high in cycle N+1 -> tx_valid high from cycle N+2.
  - Read: addr byte at edge N -> bus_rd_en cycle N+1 -> first tx byte valid cycle N+2.
  - Zero-wait tx_ready: one byte per cycle.
- Timeout:
  - In GET_ADDR/GET_DATA, a counter increments each cycle without rx_valid and clears on rx_valid.
  - When it reaches TIMEOUT_CYCLES -> IDLE, no strobe, counter cleared.
  - rx_valid in the same cycle as the terminal count: the byte is accepted and the counter cleared.
  - TIMEOUT_CYCLES=0: counter inactive.
- rx_valid in BUS_WR, BUS_RD or SEND: byte dropped. The host must wait for the response.

Optional Feature:
- Macro: RGF_UART_BUS_MASTER_ERR_EN.
- Enabled:
  - An unknown command byte in IDLE -> SEND with a single byte 0x45 ('E').
  - A timeout abort also sends 0x45.
  - Adds output err_cnt (8 bits): reset 0, increments on each error, saturates at 0xFF.
- Disabled: unknown bytes are silently discarded and timeouts return to IDLE silently; err_cnt port absent.

Test Plan:
- Write: rx 57,04,78,56,34,12 -> one-cycle bus_wr_en with bus_addr=0x04 and bus_wdata=0x12345678; then tx 0x4B; busy low afterwards.
- Read: bus_rdata=0x00ABCDEF at addr 0x0C; rx 52,0C -> one-cycle bus_rd_en, addr 0x0C; tx EF,CD,AB,00 in order. With tx_ready held low 5 cycles per byte, tx_data stays stable and no byte is repeated or skipped.
- Latency: with tx_ready=1, bus_wr_en is exactly 1 cycle after the last rx byte and tx_valid exactly 2 cycles after; read path same.
- Timeout: TIMEOUT_CYCLES=16; rx 57,08,11 then silence for 16 cycles -> IDLE, no bus_wr_en. A following rx 52,08 performs a normal read.
- Garbage and reset:
  - rx 0x00 in IDLE -> no response. With RGF_UART_BUS_MASTER_ERR_EN: tx 0x45 and err_cnt=1.
  - rst_n pulsed low after rx 57,04,01 -> all outputs 0, no strobe; the next full write frame works.
- Dropped bytes: rx byte injected during SEND -> ignored. The next frame decodes from IDLE correctly.
